mac_rx_hdr_buffer: RTL and testbench
====================================

Name: mac_rx_hdr_buffer

Overview:
- Consumes the byte stream from the MAC RX FIFO (valid/data/last/ready) and captures the first HDR_BYTES bytes of each packet into a flat header register.
- Presents the captured header to the parser FSM with a single valid/ready handshake.
- After the header is accepted, forwards the rest of the packet (payload) as a byte stream to the payload path.
- Counts packets and runt packets for status.

Parameters:
- HDR_BYTES, 34, header bytes captured per packet (14 B Ethernet + 20 B IPv4); must be >= 2.
- LEN_W, 6, width of hdr_len; must satisfy 2^LEN_W > HDR_BYTES.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  byte valid from RX FIFO (fifo_valid).
- in_data  in  8  byte from RX FIFO (fifo_data).
- in_last  in  1  last byte of packet (fifo_last).
- in_ready  out  1  to RX FIFO (fifo_ready); combinational.
- hdr_valid  out  1  header ready for parser; registered.
- hdr_data  out  HDR_BYTES*8  captured header; byte 0 in bits [HDR_BYTES*8-1 -: 8]; registered.
- hdr_len  out  LEN_W  bytes captured (1..HDR_BYTES); registered.
- hdr_runt  out  1  packet ended before HDR_BYTES bytes; registered.
- hdr_eop  out  1  packet ended exactly at or before the header end, so no payload follows; registered.
- hdr_ready  in  1  parser accepts header.
- pay_valid  out  1  payload byte valid; combinational.
- pay_data  out  8  payload byte; combinational.
- pay_last  out  1  last payload byte; combinational.
- pay_ready  in  1  payload sink ready.
- pkt_cnt  out  16  packets whose header was accepted; wraps at 16'hFFFF -> 0.
- runt_cnt  out  16  runt packets accepted; wraps.

Behaviour:
- Reset: state=CAPTURE, byte_cnt=0; hdr_valid, hdr_data, hdr_len, hdr_runt, hdr_eop, pkt_cnt and runt_cnt all 0. Reset is asynchronous and may occur mid-packet; the block then restarts at CAPTURE and treats the next accepted byte as byte 0.
- An input byte is accepted only when in_valid && in_ready.
- States:
  - CAPTURE: in_ready=1, pay_valid=0. An accepted byte is written to slot byte_cnt, then byte_cnt++.
    - Accepted with in_last and byte_cnt+1 < HDR_BYTES -> HOLD, hdr_runt=1, hdr_eop=1, hdr_len=byte_cnt+1.
    - Accepted at byte_cnt = HDR_BYTES-1 with in_last=1 -> HOLD, hdr_runt=0, hdr_eop=1, hdr_len=HDR_BYTES.
    - Accepted at byte_cnt = HDR_BYTES-1 with in_last=0 -> HOLD, hdr_runt=0, hdr_eop=0, hdr_len=HDR_BYTES.
    - hdr_valid goes high in the cycle after the terminating byte (1-cycle latency).
  - HOLD: hdr_valid=1, in_ready=0, pay_valid=0. hdr_data and the other hdr_* outputs are held stable until hdr_ready=1.
    - On hdr_valid && hdr_ready: hdr_valid goes low next cycle; pkt_cnt++; runt_cnt++ if hdr_runt.
    - If hdr_eop -> CAPTURE, with byte_cnt=0 and hdr_data cleared to 0. Otherwise -> PAYLOAD.
  - PAYLOAD: combinational passthrough: pay_valid=in_valid, pay_data=in_data, pay_last=in_last, in_ready=pay_ready.
    - An accepted byte with in_last -> CAPTURE, with byte_cnt=0 and hdr_data cleared.
- Bytes of hdr_data beyond hdr_len are always 0.
- No input byte is consumed in HOLD, so the RX FIFO absorbs parser latency.
- Back-to-back packets: the first byte of the next packet can be accepted in the cycle after the last payload byte.
- A zero-length packet cannot occur, since every packet has at least one byte with in_last.
- in_valid dropping mid-capture: byte_cnt holds and capture resumes when in_valid returns.

Test Plan:
- 60-byte packet, bytes 0x00..0x3B, all ready=1 -> hdr_valid 1 cycle after byte 33; hdr_data=0x00..0x21, hdr_len=34, runt=0, eop=0; then 26 payload bytes 0x22..0x3B with pay_last on 0x3B; pkt_cnt=1.
- 10-byte runt 0xA0..0xA9 -> hdr_len=10, hdr_runt=1, hdr_eop=1, bytes 10..33 of hdr_data = 0; no pay_valid; runt_cnt=1.
- Exactly 34-byte packet, last on byte 33 -> hdr_eop=1, runt=0, no payload; next packet captured from byte 0.
- Hold hdr_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and hdr_data stable throughout; no bytes lost after release.
- PAYLOAD with pay_ready toggling 1,0,1,0 -> in_ready mirrors pay_ready and payload bytes arrive in order with no duplicates.
- Assert rst_n low during payload byte 5 -> all outputs 0 immediately; a following 40-byte packet yields a correct header with pkt_cnt=1.

Source files
------------

// File: rtl/mac_rx_hdr_buffer_if.sv
// Signal bundle around the MAC RX header buffer: RX FIFO byte stream in,
// captured header to the parser, payload stream out, status counters.
interface mac_rx_hdr_buffer_if #(
    parameter int HDR_BYTES = 34,
    parameter int LEN_W     = 6
);
    logic                   in_valid;
    logic [7:0]             in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   hdr_valid;
    logic [HDR_BYTES*8-1:0] hdr_data;
    logic [LEN_W-1:0]       hdr_len;
    logic                   hdr_runt;
    logic                   hdr_eop;
    logic                   hdr_ready;
    logic                   pay_valid;
    logic [7:0]             pay_data;
    logic                   pay_last;
    logic                   pay_ready;
    logic [15:0]            pkt_cnt;
    logic [15:0]            runt_cnt;

    // master: the header buffer itself
    modport master (
        input  in_valid, in_data, in_last, hdr_ready, pay_ready,
        output in_ready, hdr_valid, hdr_data, hdr_len, hdr_runt, hdr_eop,
               pay_valid, pay_data, pay_last, pkt_cnt, runt_cnt
    );

    // slave: RX FIFO, parser and payload sink seen as one environment
    modport slave (
        output in_valid, in_data, in_last, hdr_ready, pay_ready,
        input  in_ready, hdr_valid, hdr_data, hdr_len, hdr_runt, hdr_eop,
               pay_valid, pay_data, pay_last, pkt_cnt, runt_cnt
    );
endinterface

// File: rtl/mac_rx_hdr_buffer.sv
// Captures the leading HDR_BYTES of each RX packet for the parser, then
// streams the remaining payload bytes straight through.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   CAPTURE | accept bytes into header slots until HDR_BYTES or in_last
//   HOLD    | header presented (hdr_valid=1), input stalled until accepted
//   PAYLOAD | pass-through of the remaining bytes until in_last
module mac_rx_hdr_buffer #(
    parameter int HDR_BYTES = 34,
    parameter int LEN_W     = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mac_rx_hdr_buffer_if.master  bus
);
    localparam int               HDR_W    = HDR_BYTES * 8;
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(HDR_BYTES - 1);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        HOLD    = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [HDR_W-1:0] hdr_data_q, hdr_data_d;
    logic [LEN_W-1:0] hdr_len_q, hdr_len_d;
    logic             hdr_valid_q, hdr_valid_d;
    logic             hdr_runt_q, hdr_runt_d;
    logic             hdr_eop_q, hdr_eop_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      runt_cnt_q, runt_cnt_d;
    logic             in_ready;
    logic             pay_valid;
    logic [7:0]       pay_data;
    logic             pay_last;

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        hdr_data_d  = hdr_data_q;
        hdr_len_d   = hdr_len_q;
        hdr_valid_d = hdr_valid_q;
        hdr_runt_d  = hdr_runt_q;
        hdr_eop_d   = hdr_eop_q;
        pkt_cnt_d   = pkt_cnt_q;
        runt_cnt_d  = runt_cnt_q;
        in_ready    = 1'b0;
        pay_valid   = 1'b0;
        pay_data    = 8'h00;
        pay_last    = 1'b0;

        unique case (state_q)
            CAPTURE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    // byte 0 lands in the most significant byte of the header
                    for (int i = 0; i < HDR_BYTES; i++) begin
                        if (LEN_W'(i) == byte_cnt_q) begin
                            hdr_data_d[(HDR_BYTES-1-i)*8 +: 8] = bus.in_data;
                        end
                    end
                    byte_cnt_d = byte_cnt_q + LEN_W'(1);
                    if (bus.in_last || (byte_cnt_q == LAST_IDX)) begin
                        state_d     = HOLD;
                        hdr_valid_d = 1'b1;
                        hdr_len_d   = byte_cnt_q + LEN_W'(1);
                        hdr_runt_d  = (byte_cnt_q != LAST_IDX);
                        hdr_eop_d   = bus.in_last;
                    end
                end
            end

            HOLD: begin
                if (bus.hdr_ready) begin
                    hdr_valid_d = 1'b0;
                    pkt_cnt_d   = pkt_cnt_q + 16'd1;
                    runt_cnt_d  = runt_cnt_q + {15'd0, hdr_runt_q};
                    if (hdr_eop_q) begin
                        state_d    = CAPTURE;
                        byte_cnt_d = '0;
                        hdr_data_d = '0;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end

            PAYLOAD: begin
                in_ready  = bus.pay_ready;
                pay_valid = bus.in_valid;
                pay_data  = bus.in_data;
                pay_last  = bus.in_last;
                if (bus.in_valid && bus.pay_ready && bus.in_last) begin
                    state_d    = CAPTURE;
                    byte_cnt_d = '0;
                    hdr_data_d = '0;
                end
            end

            default: begin
                state_d    = CAPTURE;
                byte_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CAPTURE;
            byte_cnt_q  <= '0;
            hdr_data_q  <= '0;
            hdr_len_q   <= '0;
            hdr_valid_q <= 1'b0;
            hdr_runt_q  <= 1'b0;
            hdr_eop_q   <= 1'b0;
            pkt_cnt_q   <= '0;
            runt_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            hdr_data_q  <= hdr_data_d;
            hdr_len_q   <= hdr_len_d;
            hdr_valid_q <= hdr_valid_d;
            hdr_runt_q  <= hdr_runt_d;
            hdr_eop_q   <= hdr_eop_d;
            pkt_cnt_q   <= pkt_cnt_d;
            runt_cnt_q  <= runt_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.hdr_valid = hdr_valid_q;
    assign bus.hdr_data  = hdr_data_q;
    assign bus.hdr_len   = hdr_len_q;
    assign bus.hdr_runt  = hdr_runt_q;
    assign bus.hdr_eop   = hdr_eop_q;
    assign bus.pay_valid = pay_valid;
    assign bus.pay_data  = pay_data;
    assign bus.pay_last  = pay_last;
    assign bus.pkt_cnt   = pkt_cnt_q;
    assign bus.runt_cnt  = runt_cnt_q;
endmodule

// File: tb/tb_mac_rx_hdr_buffer.sv
// Directed and randomized packets against a packet-level model: header is the
// first min(n,HDR_BYTES) bytes, payload is the rest, counters count packets.
module tb_mac_rx_hdr_buffer;
    localparam int HB = 34;
    localparam int LW = 6;
    localparam int HW = HB * 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [15:0] exp_pkt = '0;
    logic [15:0] exp_runt = '0;
    logic [7:0]  pkt [$];

    always #5 clk = ~clk;

    mac_rx_hdr_buffer_if #(.HDR_BYTES(HB), .LEN_W(LW)) bus ();

    mac_rx_hdr_buffer #(.HDR_BYTES(HB), .LEN_W(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expire(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: got no progress within cycle budget, expected completion", tag);
    endtask

    task automatic fill_seq(input int n, input logic [7:0] start);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'(start + i));
    endtask

    task automatic fill_rand(input int n);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [HW-1:0] exp_hdr();
        logic [HW-1:0] h = '0;
        for (int i = 0; i < pkt.size() && i < HB; i++) h[(HB-1-i)*8 +: 8] = pkt[i];
        return h;
    endfunction

    // Drives the packet in pkt[] through capture, hold and payload phases.
    // abort_at >= HB returns before driving that payload byte.
    task automatic send_pkt(input int gap_pct, input int hold_cycles, input int pr_mode,
                            input int abort_at);
        int            n = pkt.size();
        int            hl = (pkt.size() < HB) ? pkt.size() : HB;
        int            idx = 0;
        int            budget = 0;
        bit            ph = 1'b1;
        logic          pr;
        logic [HW-1:0] eh = exp_hdr();

        while (idx < hl) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.in_data  = pkt[idx];
            bus.in_last  = (idx == n - 1);
            #1;
            chk("cap_in_ready", bus.in_ready, 1'b1);
            chk("cap_pay_valid", bus.pay_valid, 1'b0);
            chk("cap_hdr_valid", bus.hdr_valid, 1'b0);
            @(posedge clk);
            if (bus.in_valid) idx++;
            budget++;
            if (budget > 2000) begin
                expire("cap_timeout");
                return;
            end
        end

        // header must be visible one cycle after the terminating byte
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.pay_ready = 1'b1;
        if (idx < n) begin
            bus.in_data = pkt[idx];
            bus.in_last = (idx == n - 1);
        end else begin
            bus.in_data = 8'hEE;
            bus.in_last = 1'b1;
        end
        #1;
        chk("hdr_valid_lat", bus.hdr_valid, 1'b1);
        chk("hdr_data", bus.hdr_data, eh);
        chk("hdr_len", bus.hdr_len, hl);
        chk("hdr_runt", bus.hdr_runt, n < HB);
        chk("hdr_eop", bus.hdr_eop, n <= HB);
        chk("hold_in_ready", bus.in_ready, 1'b0);
        for (int c = 0; c < hold_cycles; c++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", bus.hdr_valid, 1'b1);
            chk("hold_data", bus.hdr_data, eh);
            chk("hold_in_ready", bus.in_ready, 1'b0);
            chk("hold_pay_valid", bus.pay_valid, 1'b0);
        end
        bus.hdr_ready = 1'b1;
        @(posedge clk);
        exp_pkt++;
        if (n < HB) exp_runt++;
        @(negedge clk);
        bus.hdr_ready = 1'b0;
        bus.pay_ready = 1'b0;
        if (n <= HB) bus.in_valid = 1'b0;
        #1;
        chk("rel_hdr_valid", bus.hdr_valid, 1'b0);
        chk("pkt_cnt", bus.pkt_cnt, exp_pkt);
        chk("runt_cnt", bus.runt_cnt, exp_runt);
        if (n <= HB) begin
            chk("eop_hdr_clear", bus.hdr_data, '0);
            chk("eop_in_ready", bus.in_ready, 1'b1);
            chk("eop_pay_valid", bus.pay_valid, 1'b0);
            return;
        end

        idx = HB;
        budget = 0;
        while (idx < n) begin
            if (idx == abort_at) return;
            @(negedge clk);
            case (pr_mode)
                0:       pr = 1'b1;
                1: begin
                    pr = ph;
                    ph = ~ph;
                end
                default: pr = 1'($urandom_range(0, 1));
            endcase
            bus.pay_ready = pr;
            bus.in_valid  = ($urandom_range(0, 99) >= gap_pct);
            bus.in_data   = pkt[idx];
            bus.in_last   = (idx == n - 1);
            #1;
            chk("pay_in_ready", bus.in_ready, pr);
            chk("pay_valid", bus.pay_valid, bus.in_valid);
            if (bus.in_valid) begin
                chk("pay_data", bus.pay_data, pkt[idx]);
                chk("pay_last", bus.pay_last, idx == n - 1);
            end
            @(posedge clk);
            if (bus.in_valid && pr) idx++;
            budget++;
            if (budget > 2000) begin
                expire("pay_timeout");
                return;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.pay_ready = 1'b0;
        #1;
        chk("pay_end_hdr_clear", bus.hdr_data, '0);
        chk("pay_end_in_ready", bus.in_ready, 1'b1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.hdr_ready = 1'b0;
        bus.pay_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hdr_valid", bus.hdr_valid, 1'b0);
        chk("rst_hdr_data", bus.hdr_data, '0);
        chk("rst_hdr_len", bus.hdr_len, '0);
        chk("rst_hdr_runt", bus.hdr_runt, 1'b0);
        chk("rst_hdr_eop", bus.hdr_eop, 1'b0);
        chk("rst_pkt_cnt", bus.pkt_cnt, '0);
        chk("rst_runt_cnt", bus.runt_cnt, '0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_pay_valid", bus.pay_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        fill_seq(60, 8'h00);  send_pkt(0, 0, 0, -1);
        fill_seq(10, 8'hA0);  send_pkt(0, 0, 0, -1);
        fill_seq(34, 8'h40);  send_pkt(0, 0, 0, -1);
        fill_seq(50, 8'h10);  send_pkt(0, 5, 0, -1);
        fill_seq(45, 8'h80);  send_pkt(0, 0, 1, -1);
        fill_seq(33, 8'hC0);  send_pkt(30, 2, 0, -1);
        fill_seq(35, 8'h61);  send_pkt(0, 1, 1, -1);

        for (int k = 0; k < 25; k++) begin
            fill_rand($urandom_range(1, 70));
            send_pkt(20, $urandom_range(0, 3), 2, -1);
        end

        // asynchronous reset in the middle of payload byte 5
        fill_seq(60, 8'h00);
        send_pkt(0, 0, 0, HB + 5);
        @(negedge clk);
        bus.pay_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = pkt[HB+5];
        bus.in_last   = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_pkt  = '0;
        exp_runt = '0;
        #1;
        chk("arst_hdr_valid", bus.hdr_valid, 1'b0);
        chk("arst_hdr_data", bus.hdr_data, '0);
        chk("arst_hdr_len", bus.hdr_len, '0);
        chk("arst_hdr_runt", bus.hdr_runt, 1'b0);
        chk("arst_hdr_eop", bus.hdr_eop, 1'b0);
        chk("arst_pkt_cnt", bus.pkt_cnt, '0);
        chk("arst_runt_cnt", bus.runt_cnt, '0);
        chk("arst_pay_valid", bus.pay_valid, 1'b0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.pay_ready = 1'b0;
        rst_n = 1'b1;
        fill_seq(40, 8'h55);  send_pkt(0, 1, 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
